uart_tx_arbiter: RTL

- Shares one `uart_tx` transmitter between `N` byte-stream requesters.
- Arbitration is round-robin.
- A requester can lock the transmitter for a multi-byte message, so messages from different requesters are never interleaved.
- Sits between the requester blocks and the `send`/`data`/`busy` inputs of `uart_tx`, and sequences each byte through the transmitter's send/busy handshake.

---
 rtl/uart_pkg.sv | 13 +
 rtl/rr_pick.sv | 32 +++
 rtl/uart_tx_arbiter.sv | 91 +++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit-side blocks.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first eligible request at or after ptr, wrapping modulo N.
module rr_pick #(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic [N-1:0]  mask,
    output logic          valid,
    output logic [IW-1:0] winner
);

    logic [N-1:0]  eligible;
    logic [IW-1:0] idx;

    assign eligible = req & mask;

    // Scan from the farthest offset down so the closest hit to ptr is the one that sticks.
    always_comb begin
        valid  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = IW'((int'(ptr) + k) % N);
            if (eligible[idx]) begin
                valid  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among N byte-stream requesters, with a
// per-message lock so that multi-byte messages are never interleaved.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N      = 4,
    parameter int DATA_W = UART_DATA_W,
    localparam int IW    = $clog2(N)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N-1:0]        req,
    input  logic [N*DATA_W-1:0] req_data,
    input  logic [N-1:0]        req_last,
    output logic [N-1:0]        ack,
    output logic [IW-1:0]       grant_id,
    output logic                locked,
    output logic                tx_send,
    output logic [DATA_W-1:0]   tx_data,
    input  logic                tx_busy
);

    arb_state_t    state, state_next;
    logic [IW-1:0] ptr;
    logic [IW-1:0] ptr_after;
    logic [IW-1:0] pick_id;
    logic          pick_valid;
    logic          capture;
    logic          last_flag;
    logic [N-1:0]  grant_onehot;
    logic [N-1:0]  lock_mask;

    assign grant_onehot = N'(1) << grant_id;
    assign lock_mask    = locked ? grant_onehot : '1;
    assign ptr_after    = (int'(grant_id) == N - 1) ? '0 : grant_id + IW'(1);

    rr_pick #(.N(N)) u_pick (
        .req    (req),
        .ptr    (ptr),
        .mask   (lock_mask),
        .valid  (pick_valid),
        .winner (pick_id)
    );

    assign tx_send = (state == ISSUE);
    assign ack     = tx_send ? grant_onehot : '0;

    // tx_busy gates arbitration so a frame left running across a reset is never overrun.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        unique case (state)
            IDLE: begin
                if (!tx_busy && pick_valid) begin
                    capture    = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE:     state_next = WAIT_BUSY;
            WAIT_BUSY: if (tx_busy) state_next = WAIT_DONE;
            WAIT_DONE: if (!tx_busy) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            grant_id  <= '0;
            locked    <= 1'b0;
            tx_data   <= '0;
            last_flag <= 1'b0;
        end else begin
            state <= state_next;
            if (capture) begin
                grant_id  <= pick_id;
                tx_data   <= req_data[int'(pick_id) * DATA_W +: DATA_W];
                last_flag <= req_last[pick_id];
            end
            if (state == ISSUE) begin
                locked <= ~last_flag;
            end
            // Only a completed message hands priority on; a locked owner keeps ptr still.
            if (state == WAIT_DONE && !tx_busy && last_flag) begin
                ptr <= ptr_after;
            end
        end
    end

endmodule
